// File: rtl/risc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// risc_pkg
// Shared opcodes, state encoding, ALU function codes and instruction field
// positions for the multi-cycle 16-bit RISC core.
// Revision: 1.0
// ---------------------------------------------------------------------------
package risc_pkg;

   // Opcode map (instruction bits [15:12])
   localparam logic [3:0] OP_LD   = 4'h0;
   localparam logic [3:0] OP_ST   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_INV  = 4'h4;
   localparam logic [3:0] OP_SHL  = 4'h5;
   localparam logic [3:0] OP_SHR  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_SLT  = 4'h9;
   localparam logic [3:0] OP_ADDI = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_BNE  = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   // Control states
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // ALU function select
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_INV = 3'd2;
   localparam logic [2:0] ALU_SHL = 3'd3;
   localparam logic [2:0] ALU_SHR = 3'd4;
   localparam logic [2:0] ALU_AND = 3'd5;
   localparam logic [2:0] ALU_OR  = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   // Instruction field positions
   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 12;
   localparam int RS_MSB    = 11;
   localparam int RS_LSB    = 9;
   localparam int RT_MSB    = 8;
   localparam int RT_LSB    = 6;
   localparam int RD_MSB    = 5;
   localparam int RD_LSB    = 3;
   localparam int IMM6_MSB  = 5;
   localparam int IMM12_MSB = 11;

   // Register file geometry
   localparam int NUM_REGS = 8;
   localparam int REG_AW   = 3;

endpackage
`default_nettype wire

// File: rtl/risc_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// risc_regfile
// 8 x DATA_W register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear. r0 is an ordinary writable register.
// Revision: 1.0
// ---------------------------------------------------------------------------
module risc_regfile
   import risc_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [0:NUM_REGS-1];

   // Clear every register on reset, otherwise perform the single write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];

endmodule
`default_nettype wire

// File: rtl/risc_multicycle_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// risc_multicycle_core
// Multi-cycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB control over one
// unified req/ready memory bus. ADDR_W must be above 12 and no wider than
// DATA_W (memory addresses come from the low ADDR_W bits of the ALU).
// Revision: 1.0
// ---------------------------------------------------------------------------
module risc_multicycle_core
   import risc_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic              retire,
   output logic [ADDR_W-1:0] dbg_pc
);

   localparam int                SH_W   = $clog2(DATA_W);
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       ir;
   logic [DATA_W-1:0] a_reg, b_reg, res;

   logic [3:0]        op;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [DATA_W-1:0] imm6_d, alu_b, alu_out, rs_data, rt_data;
   logic [ADDR_W-1:0] imm6_a, imm12_a, pc_target;
   logic [2:0]        alu_fn;
   logic              use_imm, taken;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;

   assign op      = ir[OP_MSB:OP_LSB];
   assign rs      = ir[RS_MSB:RS_LSB];
   assign rt      = ir[RT_MSB:RT_LSB];
   assign rd      = ir[RD_MSB:RD_LSB];
   assign imm6_d  = {{(DATA_W-6){ir[IMM6_MSB]}}, ir[IMM6_MSB:0]};
   assign imm6_a  = {{(ADDR_W-6){ir[IMM6_MSB]}}, ir[IMM6_MSB:0]};
   assign imm12_a = {{(ADDR_W-12){ir[IMM12_MSB]}}, ir[IMM12_MSB:0]};

   // LD/ST/ADDI add the sign-extended immediate instead of the rt operand
   assign use_imm   = (op == OP_LD) || (op == OP_ST) || (op == OP_ADDI);
   assign alu_b     = use_imm ? imm6_d : b_reg;
   assign taken     = ((op == OP_BEQ) && (a_reg == b_reg)) ||
                      ((op == OP_BNE) && (a_reg != b_reg)) ||
                      (op == OP_JMP);
   // pc already points at the next instruction when EXEC runs
   assign pc_target = (op == OP_JMP) ? (pc + imm12_a) : (pc + imm6_a);

   assign halted = (state == S_HALT);
   assign dbg_pc = pc;

   risc_regfile #(
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (rs),
      .ra_data (rs_data),
      .rb_addr (rt),
      .rb_data (rt_data),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (res)
   );

   // Map opcode to ALU function; memory ops and ADDI use plain addition
   always_comb begin
      alu_fn = ALU_ADD;
      case (op)
         OP_SUB:  alu_fn = ALU_SUB;
         OP_INV:  alu_fn = ALU_INV;
         OP_SHL:  alu_fn = ALU_SHL;
         OP_SHR:  alu_fn = ALU_SHR;
         OP_AND:  alu_fn = ALU_AND;
         OP_OR:   alu_fn = ALU_OR;
         OP_SLT:  alu_fn = ALU_SLT;
         default: alu_fn = ALU_ADD;
      endcase
   end

   // ALU; shifts use only the low log2(DATA_W) bits of the amount
   always_comb begin
      alu_out = '0;
      case (alu_fn)
         ALU_ADD: alu_out = a_reg + alu_b;
         ALU_SUB: alu_out = a_reg - alu_b;
         ALU_INV: alu_out = ~a_reg;
         ALU_SHL: alu_out = a_reg << alu_b[SH_W-1:0];
         ALU_SHR: alu_out = a_reg >> alu_b[SH_W-1:0];
         ALU_AND: alu_out = a_reg & alu_b;
         ALU_OR:  alu_out = a_reg | alu_b;
         ALU_SLT: alu_out = {{(DATA_W-1){1'b0}}, (a_reg < alu_b)};
         default: alu_out = '0;
      endcase
   end

   // State register; reset abandons any in-flight transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, bus outputs, retire and register write enables
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      rf_we     = 1'b0;
      rf_waddr  = rd;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            case (op)
               OP_LD, OP_ST: state_nxt = S_MEM;
               OP_BEQ, OP_BNE, OP_JMP, OP_NOP: begin
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
               OP_HALT: begin
                  retire    = 1'b1;
                  state_nxt = S_HALT;
               end
               default: state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = (op == OP_ST);
            mem_addr  = res[ADDR_W-1:0];
            mem_wdata = b_reg;
            if (mem_ready) begin
               if (op == OP_ST) begin
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            rf_waddr  = ((op == OP_LD) || (op == OP_ADDI)) ? rt : rd;
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
      // Bus and pulses are quiet for as long as reset is held
      if (rst) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         retire    = 1'b0;
         rf_we     = 1'b0;
      end
   end

   // Datapath registers: PC, IR, operand latches and result/load data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= RESET_PC;
         ir    <= '0;
         a_reg <= '0;
         b_reg <= '0;
         res   <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata[15:0];
                  pc <= pc + PC_ONE;
               end
            end
            S_DECODE: begin
               a_reg <= rs_data;
               b_reg <= rt_data;
            end
            S_EXEC: begin
               res <= alu_out;
               if (taken) pc <= pc_target;
            end
            S_MEM: begin
               if (mem_ready && (op == OP_LD)) res <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
